// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter (CPU data port and debug/loader) sharing one single-port RAM.
// Grants are combinational and bounded-burst fair; read data returns one cycle after the grant.
module ram_port_arbiter #(
   parameter int BURST_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [10:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [10:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic [10:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic        ram_w_en,
   input  logic [31:0] ram_rdata,
   output logic [1:0]  owner
);

   localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(BURST_MAX - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      OWN_CPU = 2'b01,
      OWN_DBG = 2'b10
   } state_t;

   // Handshake: a requester holds req/we/addr/wdata until it sees its gnt in the
   // same cycle; the access completes in that cycle and nothing is buffered.
   state_t        state, state_nxt;
   logic          last_dbg, last_dbg_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          gnt_c, gnt_d;
   logic          cpu_rd_q, dbg_rd_q;

   always_comb begin
      gnt_c = 1'b0;
      gnt_d = 1'b0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (cpu_req && dbg_req) begin
                  gnt_c = last_dbg;
                  gnt_d = !last_dbg;
               end else begin
                  gnt_c = cpu_req;
                  gnt_d = dbg_req;
               end
            end
            // The owner keeps the port unless its burst is spent and the other side waits.
            OWN_CPU: begin
               if (cpu_req && ((cnt < CNT_TOP) || !dbg_req)) gnt_c = 1'b1;
               else if (dbg_req)                             gnt_d = 1'b1;
            end
            OWN_DBG: begin
               if (dbg_req && ((cnt < CNT_TOP) || !cpu_req)) gnt_d = 1'b1;
               else if (cpu_req)                             gnt_c = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt    = IDLE;
      cnt_nxt      = '0;
      last_dbg_nxt = last_dbg;
      if (gnt_c) begin
         state_nxt    = OWN_CPU;
         last_dbg_nxt = 1'b0;
         if (state == OWN_CPU) cnt_nxt = (cnt == CNT_TOP) ? cnt : cnt + CW'(1);
      end else if (gnt_d) begin
         state_nxt    = OWN_DBG;
         last_dbg_nxt = 1'b1;
         if (state == OWN_DBG) cnt_nxt = (cnt == CNT_TOP) ? cnt : cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_dbg <= 1'b1;
         cnt      <= '0;
         cpu_rd_q <= 1'b0;
         dbg_rd_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         last_dbg <= last_dbg_nxt;
         cnt      <= cnt_nxt;
         cpu_rd_q <= gnt_c && !cpu_we;
         dbg_rd_q <= gnt_d && !dbg_we;
      end
   end

   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_w_en  = 1'b0;
      if (gnt_c) begin
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         ram_w_en  = cpu_we;
      end else if (gnt_d) begin
         ram_addr  = dbg_addr;
         ram_wdata = dbg_wdata;
         ram_w_en  = dbg_we;
      end
   end

   assign cpu_gnt    = gnt_c;
   assign dbg_gnt    = gnt_d;
   assign cpu_rvalid = cpu_rd_q;
   assign dbg_rvalid = dbg_rd_q;
   assign cpu_rdata  = cpu_rd_q ? ram_rdata : '0;
   assign dbg_rdata  = dbg_rd_q ? ram_rdata : '0;
   assign owner      = state;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic checked
// against a burst-count reference model and a model memory.
module tb_ram_port_arbiter;

   localparam int BM = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [10:0] cpu_addr, dbg_addr;
   logic [31:0] cpu_wdata, dbg_wdata;
   logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [31:0] cpu_rdata, dbg_rdata;
   logic [10:0] ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic        ram_w_en;
   logic [1:0]  owner;

   ram_port_arbiter #(.BURST_MAX(BM)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_w_en(ram_w_en),
      .ram_rdata(ram_rdata), .owner(owner)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // Environment RAM: synchronous read of the presented address, read-first.
   logic [31:0] ram_mem [2048];
   always @(posedge clk) begin
      if (ram_w_en) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   // ---------------- reference model ----------------
   logic [31:0] mmem [2048];
   int          holder;   // 0 none, 1 cpu, 2 dbg
   int          last;     // last requester granted
   int          run;      // consecutive grants to holder
   logic        exp_c_rv, exp_d_rv;
   logic [31:0] exp_c_rd, exp_d_rd;
   int          last_g, got_g;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [1:0]  exp_q [$];
   logic [1:0]  got_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input bit c, input bit d);
      bit x, y;
      if (holder == 0) begin
         if (c && d) return (last == 2) ? 1 : 2;
         if (c) return 1;
         if (d) return 2;
         return 0;
      end
      x = (holder == 1) ? c : d;
      y = (holder == 1) ? d : c;
      if (x && (run < BM || !y)) return holder;
      if (y) return 3 - holder;
      return 0;
   endfunction

   // Check one cycle's outputs against the model, then advance the model.
   task automatic cycle_check();
      int          g;
      logic [10:0] ea;
      logic [31:0] ew;
      logic        ewe;
      #1;
      g     = pick(cpu_req, dbg_req);
      got_g = cpu_gnt ? 1 : (dbg_gnt ? 2 : 0);
      ea = '0; ew = '0; ewe = 1'b0;
      if (g == 1) begin ea = cpu_addr; ew = cpu_wdata; ewe = cpu_we; end
      if (g == 2) begin ea = dbg_addr; ew = dbg_wdata; ewe = dbg_we; end
      chk("owner",      32'(owner),      32'(holder));
      chk("cpu_gnt",    32'(cpu_gnt),    32'(g == 1));
      chk("dbg_gnt",    32'(dbg_gnt),    32'(g == 2));
      chk("ram_addr",   32'(ram_addr),   32'(ea));
      chk("ram_wdata",  ram_wdata,       ew);
      chk("ram_w_en",   32'(ram_w_en),   32'(ewe));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_c_rv));
      chk("cpu_rdata",  cpu_rdata,       exp_c_rv ? exp_c_rd : 32'h0);
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(exp_d_rv));
      chk("dbg_rdata",  dbg_rdata,       exp_d_rv ? exp_d_rd : 32'h0);
      exp_c_rv = (g == 1) && !cpu_we;
      exp_d_rv = (g == 2) && !dbg_we;
      exp_c_rd = mmem[cpu_addr];
      exp_d_rd = mmem[dbg_addr];
      if (g == 1 && cpu_we) mmem[cpu_addr] = cpu_wdata;
      if (g == 2 && dbg_we) mmem[dbg_addr] = dbg_wdata;
      if (g == 0) begin
         holder = 0;
         run    = 0;
      end else begin
         run    = (g == holder) ? run + 1 : 1;
         holder = g;
         last   = g;
      end
      last_g = g;
      @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_cpu();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
   endtask

   task automatic idle_dbg();
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
   endtask

   function automatic logic [10:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return 11'h7FF;
      return 11'($urandom_range(0, 15));
   endfunction

   task automatic new_cpu();
      cpu_req = 1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = rand_addr(); cpu_wdata = $urandom();
   endtask

   task automatic new_dbg();
      dbg_req = 1; dbg_we = 1'($urandom_range(0, 1)); dbg_addr = rand_addr(); dbg_wdata = $urandom();
   endtask

   // Assert reset with requests pending, check the quiet outputs, release at a negedge.
   task automatic do_reset();
      rst_n = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 11'h123; cpu_wdata = 32'hA5A5_0001;
      dbg_req = 1; dbg_we = 1; dbg_addr = 11'h456; dbg_wdata = 32'h5A5A_0002;
      #1;
      chk("rst_owner",      32'(owner),      32'h0);
      chk("rst_cpu_gnt",    32'(cpu_gnt),    32'h0);
      chk("rst_dbg_gnt",    32'(dbg_gnt),    32'h0);
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
      chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
      chk("rst_ram_w_en",   32'(ram_w_en),   32'h0);
      chk("rst_ram_addr",   32'(ram_addr),   32'h0);
      chk("rst_ram_wdata",  ram_wdata,       32'h0);
      @(negedge clk);
      @(negedge clk);
      idle_cpu();
      idle_dbg();
      rst_n    = 1;
      holder   = 0;
      last     = 2;
      run      = 0;
      exp_c_rv = 0;
      exp_d_rv = 0;
      last_g   = 0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 2048; i++) begin
         ram_mem[i] = 32'(i) * 32'h0101_0101;
         mmem[i]    = 32'(i) * 32'h0101_0101;
      end
      exp_c_rd = '0;
      exp_d_rd = '0;
      do_reset();

      // Both read from reset, then keep both requesting: CPU x4, DBG x4, CPU x4.
      cpu_req = 1; cpu_addr = 11'd5;
      dbg_req = 1; dbg_addr = 11'd6;
      for (int i = 0; i < 3 * BM; i++) begin
         cycle_check();
         got_q.push_back(2'(got_g));
         exp_q.push_back(((i / BM) % 2 == 0) ? 2'd1 : 2'd2);
      end
      for (int i = 0; i < 3 * BM; i++)
         chk($sformatf("burst_pattern_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

      // CPU alone for 10 cycles, then the debug side is granted immediately.
      do_reset();
      cpu_req = 1; cpu_addr = 11'd9;
      for (int i = 0; i < 10; i++) cycle_check();
      dbg_req = 1; dbg_addr = 11'd10;
      cycle_check();
      chk("saturated_dbg_gnt", 32'(got_g), 32'd2);

      // Debug write to the top word; no rvalid follows, then an idle cycle.
      do_reset();
      dbg_req = 1; dbg_we = 1; dbg_addr = 11'h7FF; dbg_wdata = 32'hDEADBEEF;
      cycle_check();
      idle_dbg();
      cycle_check();
      chk("idle_after_write_owner", 32'(owner), 32'h0);
      cycle_check();

      // Read-back of the written word through the CPU port.
      cpu_req = 1; cpu_addr = 11'h7FF;
      cycle_check();
      idle_cpu();
      cycle_check();

      // Reset the cycle after a CPU read grant discards the pending rvalid.
      cpu_req = 1; cpu_addr = 11'd3;
      cycle_check();
      idle_cpu();
      rst_n = 0;
      #1;
      chk("rst_kills_rvalid", 32'(cpu_rvalid), 32'h0);
      do_reset();
      cycle_check();

      // Random traffic: requests held until granted, occasional withdrawal.
      for (int n = 0; n < 1500; n++) begin
         if (cpu_req) begin
            if (last_g == 1) begin
               if ($urandom_range(0, 3) != 0) new_cpu();
               else idle_cpu();
            end else if ($urandom_range(0, 19) == 0) idle_cpu();
         end else if ($urandom_range(0, 2) == 0) new_cpu();
         if (dbg_req) begin
            if (last_g == 2) begin
               if ($urandom_range(0, 3) != 0) new_dbg();
               else idle_dbg();
            end else if ($urandom_range(0, 19) == 0) idle_dbg();
         end else if ($urandom_range(0, 2) == 0) new_dbg();
         cycle_check();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
